// File: rtl/trap_entry_ctrl_if.sv
// Bundle of trap, return, CSR-write and redirect signals shared by the trap entry
// controller (slave side) and the pipeline front end that feeds it (master side).
interface trap_entry_ctrl_if;
  logic        exc_target_m;
  logic        exc_target_s;
  logic [63:0] exc_cause;
  logic [63:0] pc;
  logic [63:0] tval;
  logic        int_target_m;
  logic        int_target_s;
  logic [63:0] int_cause;
  logic        mret;
  logic        sret;
  logic [63:0] mtvec;
  logic [63:0] stvec;
  logic        csr_write;
  logic [11:0] csr_addr;
  logic [63:0] data_csr;
  logic        redirect_ready;

  logic [3:0]  priv;
  logic [63:0] mepc;
  logic [63:0] mcause;
  logic [63:0] mtval;
  logic [63:0] sepc;
  logic [63:0] scause;
  logic [63:0] stval;
  logic        mie;
  logic        mpie;
  logic        sie;
  logic        spie;
  logic        spp;
  logic [1:0]  mpp;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush;
  logic        busy;

  modport slave (
    input  exc_target_m, exc_target_s, exc_cause, pc, tval,
    input  int_target_m, int_target_s, int_cause, mret, sret, mtvec, stvec,
    input  csr_write, csr_addr, data_csr, redirect_ready,
    output priv, mepc, mcause, mtval, sepc, scause, stval,
    output mie, mpie, sie, spie, spp, mpp,
    output redirect_valid, redirect_pc, flush, busy
  );

  modport master (
    output exc_target_m, exc_target_s, exc_cause, pc, tval,
    output int_target_m, int_target_s, int_cause, mret, sret, mtvec, stvec,
    output csr_write, csr_addr, data_csr, redirect_ready,
    input  priv, mepc, mcause, mtval, sepc, scause, stval,
    input  mie, mpie, sie, spie, spp, mpp,
    input  redirect_valid, redirect_pc, flush, busy
  );
endinterface

// File: rtl/trap_entry_ctrl.sv
// Trap entry / xRET controller: takes one trap or return per idle cycle, updates the
// M/S trap CSRs and privilege, and holds a redirect until accepted. Macro: TRAP_VECTORED_EN.
module trap_entry_ctrl (
  input  logic             clk,
  input  logic             rst,
  trap_entry_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  localparam logic [3:0]  PRIV_M = 4'b1000;
  localparam logic [3:0]  PRIV_S = 4'b0010;
  localparam logic [3:0]  PRIV_U = 4'b0001;

  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;
  localparam logic [11:0] ADDR_SEPC   = 12'h141;
  localparam logic [11:0] ADDR_SCAUSE = 12'h142;
  localparam logic [11:0] ADDR_STVAL  = 12'h143;

`ifdef TRAP_VECTORED_EN
  localparam logic VEC_EN = 1'b1;
`else
  localparam logic VEC_EN = 1'b0;
`endif

  function automatic logic [1:0] priv_to_mpp(input logic [3:0] p);
    logic [1:0] m;
    case (p)
      PRIV_M:  m = 2'b11;
      PRIV_S:  m = 2'b01;
      default: m = 2'b00;
    endcase
    return m;
  endfunction

  // Reserved encoding 2'b10 falls back to U.
  function automatic logic [3:0] mpp_to_priv(input logic [1:0] m);
    logic [3:0] p;
    case (m)
      2'b11:   p = PRIV_M;
      2'b01:   p = PRIV_S;
      default: p = PRIV_U;
    endcase
    return p;
  endfunction

  function automatic logic [63:0] trap_target(input logic [63:0] tvec,
                                              input logic        is_int,
                                              input logic [63:0] cause);
    logic [63:0] base;
    logic [63:0] offs;
    base = {tvec[63:2], 2'b00};
    offs = {cause[61:0], 2'b00};
    if (VEC_EN && is_int && (tvec[1:0] == 2'b01)) begin
      return base + offs;
    end
    return base;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  priv_q, priv_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mtval_q, mtval_d;
  logic [63:0] sepc_q, sepc_d;
  logic [63:0] scause_q, scause_d;
  logic [63:0] stval_q, stval_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        sie_q, sie_d;
  logic        spie_q, spie_d;
  logic        spp_q, spp_d;
  logic [1:0]  mpp_q, mpp_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic        flush_q, flush_d;

  logic        idle;
  logic        take_exc_m, take_exc_s, take_int_m, take_int_s, take_mret, take_sret;
  logic        take_m_trap, take_s_trap, take_int, accept;
  logic [63:0] trap_cause, trap_tval;
  logic        unused_ok;

  assign idle = (state_q == IDLE);

  // Fixed priority; anything below the winner in the same cycle is dropped.
  assign take_exc_m = idle & bus.exc_target_m;
  assign take_exc_s = idle & ~bus.exc_target_m & bus.exc_target_s;
  assign take_int_m = idle & ~bus.exc_target_m & ~bus.exc_target_s & bus.int_target_m;
  assign take_int_s = idle & ~bus.exc_target_m & ~bus.exc_target_s & ~bus.int_target_m
                    & bus.int_target_s;
  assign take_mret  = idle & ~bus.exc_target_m & ~bus.exc_target_s & ~bus.int_target_m
                    & ~bus.int_target_s & bus.mret;
  assign take_sret  = idle & ~bus.exc_target_m & ~bus.exc_target_s & ~bus.int_target_m
                    & ~bus.int_target_s & ~bus.mret & bus.sret;

  assign take_m_trap = take_exc_m | take_int_m;
  assign take_s_trap = take_exc_s | take_int_s;
  assign take_int    = take_int_m | take_int_s;
  assign accept      = take_m_trap | take_s_trap | take_mret | take_sret;

  assign trap_cause = take_int ? {1'b1, bus.int_cause[62:0]} : bus.exc_cause;
  assign trap_tval  = take_int ? 64'd0 : bus.tval;

  assign unused_ok = &{1'b0, bus.int_cause[63]};

  always_comb begin
    state_d       = state_q;
    priv_d        = priv_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    sepc_d        = sepc_q;
    scause_d      = scause_q;
    stval_d       = stval_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    sie_d         = sie_q;
    spie_d        = spie_q;
    spp_d         = spp_q;
    mpp_d         = mpp_q;
    redirect_pc_d = redirect_pc_q;
    flush_d       = 1'b0;

    // Software CSR writes land first so a same-cycle trap update overrides them.
    if (bus.csr_write) begin
      case (bus.csr_addr)
        ADDR_MEPC:   mepc_d   = {bus.data_csr[63:2], 2'b00};
        ADDR_MCAUSE: mcause_d = bus.data_csr;
        ADDR_MTVAL:  mtval_d  = bus.data_csr;
        ADDR_SEPC:   sepc_d   = {bus.data_csr[63:2], 2'b00};
        ADDR_SCAUSE: scause_d = bus.data_csr;
        ADDR_STVAL:  stval_d  = bus.data_csr;
        default: ;
      endcase
    end

    if (take_m_trap) begin
      mepc_d        = bus.pc;
      mcause_d      = trap_cause;
      mtval_d       = trap_tval;
      mpie_d        = mie_q;
      mie_d         = 1'b0;
      mpp_d         = priv_to_mpp(priv_q);
      priv_d        = PRIV_M;
      redirect_pc_d = trap_target(bus.mtvec, take_int, bus.int_cause);
    end

    if (take_s_trap) begin
      sepc_d        = bus.pc;
      scause_d      = trap_cause;
      stval_d       = trap_tval;
      spie_d        = sie_q;
      sie_d         = 1'b0;
      spp_d         = (priv_q == PRIV_S);
      priv_d        = PRIV_S;
      redirect_pc_d = trap_target(bus.stvec, take_int, bus.int_cause);
    end

    // Returns use the registered epc/status, never a value being written this cycle.
    if (take_mret) begin
      redirect_pc_d = mepc_q;
      priv_d        = mpp_to_priv(mpp_q);
      mie_d         = mpie_q;
      mpie_d        = 1'b1;
      mpp_d         = 2'b00;
    end

    if (take_sret) begin
      redirect_pc_d = sepc_q;
      priv_d        = spp_q ? PRIV_S : PRIV_U;
      sie_d         = spie_q;
      spie_d        = 1'b1;
      spp_d         = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REDIRECT;
          flush_d = 1'b1;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      priv_q        <= PRIV_M;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      sepc_q        <= '0;
      scause_q      <= '0;
      stval_q       <= '0;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      sie_q         <= 1'b0;
      spie_q        <= 1'b0;
      spp_q         <= 1'b0;
      mpp_q         <= 2'b11;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      priv_q        <= priv_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      sepc_q        <= sepc_d;
      scause_q      <= scause_d;
      stval_q       <= stval_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      sie_q         <= sie_d;
      spie_q        <= spie_d;
      spp_q         <= spp_d;
      mpp_q         <= mpp_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
    end
  end

  assign bus.priv           = priv_q;
  assign bus.mepc           = mepc_q;
  assign bus.mcause         = mcause_q;
  assign bus.mtval          = mtval_q;
  assign bus.sepc           = sepc_q;
  assign bus.scause         = scause_q;
  assign bus.stval          = stval_q;
  assign bus.mie            = mie_q;
  assign bus.mpie           = mpie_q;
  assign bus.sie            = sie_q;
  assign bus.spie           = spie_q;
  assign bus.spp            = spp_q;
  assign bus.mpp            = mpp_q;
  assign bus.redirect_valid = (state_q == REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.busy           = (state_q == REDIRECT);

endmodule

// File: tb/tb_trap_entry_ctrl.sv
// Self-checking bench for trap_entry_ctrl: expected redirect target and privilege are
// queued when each event is driven and compared when the redirect appears.
module tb_trap_entry_ctrl;

  logic clk;
  logic rst;

  trap_entry_ctrl_if bus ();

  trap_entry_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  priv;
  } exp_t;

  exp_t sb[$];
  int   tests_run;
  int   tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    bus.exc_target_m = 1'b0;
    bus.exc_target_s = 1'b0;
    bus.int_target_m = 1'b0;
    bus.int_target_s = 1'b0;
    bus.mret         = 1'b0;
    bus.sret         = 1'b0;
    bus.csr_write    = 1'b0;
  endtask

  task automatic clear_all();
    clear_events();
    bus.exc_cause      = '0;
    bus.pc             = '0;
    bus.tval           = '0;
    bus.int_cause      = '0;
    bus.mtvec          = '0;
    bus.stvec          = '0;
    bus.csr_addr       = '0;
    bus.data_csr       = '0;
    bus.redirect_ready = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [63:0] data);
    bus.csr_write = 1'b1;
    bus.csr_addr  = addr;
    bus.data_csr  = data;
    step();
    bus.csr_write = 1'b0;
  endtask

  task automatic release_redirect();
    bus.redirect_ready = 1'b1;
    step();
    bus.redirect_ready = 1'b0;
  endtask

  task automatic wait_redirect(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.redirect_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    clear_all();
    rst = 1'b1;
    step();
    step();
    tests_run++;
    if (bus.priv !== 4'b1000) begin
      tests_failed++; $display("FAIL reset_priv: got %b want 1000", bus.priv);
    end
    tests_run++;
    if ({bus.mie, bus.mpie, bus.sie, bus.spie, bus.spp, bus.mpp} !== 7'b0000011) begin
      tests_failed++;
      $display("FAIL reset_status: got %b want 0000011",
               {bus.mie, bus.mpie, bus.sie, bus.spie, bus.spp, bus.mpp});
    end
    tests_run++;
    if ((bus.mepc | bus.mcause | bus.mtval | bus.sepc | bus.scause | bus.stval
         | bus.redirect_pc) !== 64'd0) begin
      tests_failed++; $display("FAIL reset_csrs: some 64-bit register nonzero");
    end
    tests_run++;
    if ({bus.redirect_valid, bus.flush, bus.busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 000", {bus.redirect_valid, bus.flush, bus.busy});
    end
    rst = 1'b0;
  endtask

  // M exception and M interrupt in the same cycle, then a long stall in REDIRECT.
  task automatic test_priority_stall();
    bit   seen;
    bit   stable;
    exp_t e;
    bus.mtvec        = 64'h1001;
    bus.exc_target_m = 1'b1;
    bus.int_target_m = 1'b1;
    bus.exc_cause    = 64'd2;
    bus.int_cause    = 64'd7;
    bus.pc           = 64'h8000_2000;
    bus.tval         = 64'h55;
    sb.push_back('{pc: 64'h1000, priv: 4'b1000});
    step();
    clear_events();
    wait_redirect(seen);
    tests_run++;
    if (!seen) begin
      tests_failed++; $display("FAIL prio_redirect: got no redirect want redirect_valid");
    end else if (sb.size() == 0) begin
      tests_failed++; $display("FAIL prio_sb: got empty queue want entry");
    end else begin
      e = sb.pop_front();
      if (bus.redirect_pc !== e.pc || bus.priv !== e.priv) begin
        tests_failed++;
        $display("FAIL prio_redirect: got pc=%h priv=%b want pc=%h priv=%b",
                 bus.redirect_pc, bus.priv, e.pc, e.priv);
      end
    end
    tests_run++;
    if (bus.flush !== 1'b1) begin
      tests_failed++; $display("FAIL prio_flush: got %b want 1", bus.flush);
    end
    tests_run++;
    if (bus.mcause !== 64'd2 || bus.mtval !== 64'h55 || bus.mepc !== 64'h8000_2000) begin
      tests_failed++;
      $display("FAIL prio_csrs: got mcause=%h mtval=%h mepc=%h want 2 55 80002000",
               bus.mcause, bus.mtval, bus.mepc);
    end
    tests_run++;
    if ({bus.mpp, bus.mpie, bus.mie} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL prio_status: got %b want 1100", {bus.mpp, bus.mpie, bus.mie});
    end
    step();
    tests_run++;
    if (bus.flush !== 1'b0) begin
      tests_failed++; $display("FAIL prio_flush_once: got %b want 0", bus.flush);
    end
    stable = 1'b1;
    csr_wr(12'h143, 64'h77);
    for (int i = 0; i < 5; i++) begin
      bus.exc_target_m = 1'b1;
      bus.exc_cause    = 64'h33;
      bus.pc           = 64'h9999_0000 + 64'(i);
      step();
      if (bus.redirect_valid !== 1'b1 || bus.busy !== 1'b1 || bus.redirect_pc !== 64'h1000
          || bus.mcause !== 64'd2 || bus.flush !== 1'b0) stable = 1'b0;
    end
    clear_events();
    tests_run++;
    if (stable !== 1'b1) begin
      tests_failed++; $display("FAIL stall_hold: got unstable redirect want held for 5 cycles");
    end
    tests_run++;
    if (bus.stval !== 64'h77) begin
      tests_failed++; $display("FAIL stall_csr_write: got %h want 77", bus.stval);
    end
    release_redirect();
    tests_run++;
    if ({bus.redirect_valid, bus.busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL stall_release: got %b want 00", {bus.redirect_valid, bus.busy});
    end
  endtask

  // Two back-to-back mrets: M (mpp=11) then U (mpp=00); also epc low-bit masking.
  task automatic test_mret_chain();
    bit   seen;
    exp_t e;
    csr_wr(12'h341, 64'h3007);
    tests_run++;
    if (bus.mepc !== 64'h3004) begin
      tests_failed++; $display("FAIL mepc_mask: got %h want 3004", bus.mepc);
    end
    for (int k = 0; k < 2; k++) begin
      bus.mret = 1'b1;
      sb.push_back('{pc: 64'h3004, priv: (k == 0) ? 4'b1000 : 4'b0001});
      step();
      clear_events();
      wait_redirect(seen);
      tests_run++;
      if (!seen || sb.size() == 0) begin
        tests_failed++; $display("FAIL mret%0d_redirect: got none want redirect", k);
      end else begin
        e = sb.pop_front();
        if (bus.redirect_pc !== e.pc || bus.priv !== e.priv) begin
          tests_failed++;
          $display("FAIL mret%0d_redirect: got pc=%h priv=%b want pc=%h priv=%b",
                   k, bus.redirect_pc, bus.priv, e.pc, e.priv);
        end
      end
      tests_run++;
      if ({bus.mie, bus.mpie, bus.mpp} !== ((k == 0) ? 4'b0100 : 4'b1100)) begin
        tests_failed++;
        $display("FAIL mret%0d_status: got %b want %b", k, {bus.mie, bus.mpie, bus.mpp},
                 (k == 0) ? 4'b0100 : 4'b1100);
      end
      bus.redirect_ready = 1'b1;
      step();
      bus.redirect_ready = 1'b0;
    end
  endtask

  task automatic test_s_exception();
    bit   seen;
    exp_t e;
    bus.exc_target_s = 1'b1;
    bus.exc_cause    = 64'd13;
    bus.pc           = 64'h8000_1004;
    bus.tval         = 64'hDEAD;
    bus.stvec        = 64'h8000_0201;
    sb.push_back('{pc: 64'h8000_0200, priv: 4'b0010});
    step();
    clear_events();
    wait_redirect(seen);
    tests_run++;
    if (!seen || sb.size() == 0) begin
      tests_failed++; $display("FAIL sexc_redirect: got none want redirect");
    end else begin
      e = sb.pop_front();
      if (bus.redirect_pc !== e.pc || bus.priv !== e.priv) begin
        tests_failed++;
        $display("FAIL sexc_redirect: got pc=%h priv=%b want pc=%h priv=%b",
                 bus.redirect_pc, bus.priv, e.pc, e.priv);
      end
    end
    tests_run++;
    if (bus.sepc !== 64'h8000_1004 || bus.scause !== 64'd13 || bus.stval !== 64'hDEAD) begin
      tests_failed++;
      $display("FAIL sexc_csrs: got sepc=%h scause=%h stval=%h want 80001004 d dead",
               bus.sepc, bus.scause, bus.stval);
    end
    tests_run++;
    if ({bus.spp, bus.sie, bus.flush} !== 3'b001) begin
      tests_failed++; $display("FAIL sexc_spp_flush: got %b want 001", {bus.spp, bus.sie, bus.flush});
    end
    step();
    tests_run++;
    if (bus.flush !== 1'b0) begin
      tests_failed++; $display("FAIL sexc_flush_once: got %b want 0", bus.flush);
    end
    release_redirect();
  endtask

  task automatic test_m_interrupt();
    bit          seen;
    exp_t        e;
    logic [63:0] want_pc;
`ifdef TRAP_VECTORED_EN
    want_pc = 64'h101C;
`else
    want_pc = 64'h1000;
`endif
    bus.int_target_m = 1'b1;
    bus.int_cause    = 64'd7;
    bus.mtvec        = 64'h1001;
    bus.pc           = 64'h8000_0300;
    bus.tval         = 64'h1234;
    sb.push_back('{pc: want_pc, priv: 4'b1000});
    step();
    clear_events();
    wait_redirect(seen);
    tests_run++;
    if (!seen || sb.size() == 0) begin
      tests_failed++; $display("FAIL mint_redirect: got none want redirect");
    end else begin
      e = sb.pop_front();
      if (bus.redirect_pc !== e.pc || bus.priv !== e.priv) begin
        tests_failed++;
        $display("FAIL mint_redirect: got pc=%h priv=%b want pc=%h priv=%b",
                 bus.redirect_pc, bus.priv, e.pc, e.priv);
      end
    end
    tests_run++;
    if (bus.mcause !== 64'h8000_0000_0000_0007 || bus.mtval !== 64'd0) begin
      tests_failed++;
      $display("FAIL mint_cause: got mcause=%h mtval=%h want 8000000000000007 0",
               bus.mcause, bus.mtval);
    end
    tests_run++;
    if ({bus.mpie, bus.mie, bus.mpp} !== 4'b1001) begin
      tests_failed++; $display("FAIL mint_status: got %b want 1001", {bus.mpie, bus.mie, bus.mpp});
    end
    release_redirect();
  endtask

  task automatic test_mret_reset_abort();
    bit   seen;
    exp_t e;
    csr_wr(12'h341, 64'h2000);
    bus.mret = 1'b1;
    sb.push_back('{pc: 64'h2000, priv: 4'b0010});
    step();
    clear_events();
    wait_redirect(seen);
    tests_run++;
    if (!seen || sb.size() == 0) begin
      tests_failed++; $display("FAIL mret_s_redirect: got none want redirect");
    end else begin
      e = sb.pop_front();
      if (bus.redirect_pc !== e.pc || bus.priv !== e.priv) begin
        tests_failed++;
        $display("FAIL mret_s_redirect: got pc=%h priv=%b want pc=%h priv=%b",
                 bus.redirect_pc, bus.priv, e.pc, e.priv);
      end
    end
    tests_run++;
    if ({bus.mie, bus.mpie, bus.mpp} !== 4'b1100) begin
      tests_failed++; $display("FAIL mret_s_status: got %b want 1100", {bus.mie, bus.mpie, bus.mpp});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (bus.priv !== 4'b1000 || bus.redirect_valid !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_abort: got priv=%b valid=%b busy=%b want 1000 0 0",
               bus.priv, bus.redirect_valid, bus.busy);
    end
  endtask

  // sret reads sepc before a same-cycle write; then a trap beats a same-cycle CSR write.
  task automatic test_csr_conflicts();
    bit   seen;
    exp_t e;
    csr_wr(12'h141, 64'h4000);
    bus.sret      = 1'b1;
    bus.csr_write = 1'b1;
    bus.csr_addr  = 12'h141;
    bus.data_csr  = 64'h5001;
    sb.push_back('{pc: 64'h4000, priv: 4'b0001});
    step();
    clear_events();
    wait_redirect(seen);
    tests_run++;
    if (!seen || sb.size() == 0) begin
      tests_failed++; $display("FAIL sret_redirect: got none want redirect");
    end else begin
      e = sb.pop_front();
      if (bus.redirect_pc !== e.pc || bus.priv !== e.priv) begin
        tests_failed++;
        $display("FAIL sret_redirect: got pc=%h priv=%b want pc=%h priv=%b",
                 bus.redirect_pc, bus.priv, e.pc, e.priv);
      end
    end
    tests_run++;
    if (bus.sepc !== 64'h5000 || {bus.sie, bus.spie, bus.spp} !== 3'b010) begin
      tests_failed++;
      $display("FAIL sret_state: got sepc=%h sie/spie/spp=%b want 5000 010",
               bus.sepc, {bus.sie, bus.spie, bus.spp});
    end
    release_redirect();
    bus.exc_target_s = 1'b1;
    bus.exc_cause    = 64'd5;
    bus.pc           = 64'h600;
    bus.tval         = 64'd0;
    bus.stvec        = 64'h8000_0000;
    bus.csr_write    = 1'b1;
    bus.csr_addr     = 12'h142;
    bus.data_csr     = 64'h99;
    sb.push_back('{pc: 64'h8000_0000, priv: 4'b0010});
    step();
    clear_events();
    wait_redirect(seen);
    tests_run++;
    if (!seen || sb.size() == 0) begin
      tests_failed++; $display("FAIL conflict_redirect: got none want redirect");
    end else begin
      e = sb.pop_front();
      if (bus.redirect_pc !== e.pc || bus.priv !== e.priv) begin
        tests_failed++;
        $display("FAIL conflict_redirect: got pc=%h priv=%b want pc=%h priv=%b",
                 bus.redirect_pc, bus.priv, e.pc, e.priv);
      end
    end
    tests_run++;
    if (bus.scause !== 64'd5 || bus.sepc !== 64'h600) begin
      tests_failed++;
      $display("FAIL conflict_event_wins: got scause=%h sepc=%h want 5 600", bus.scause, bus.sepc);
    end
    release_redirect();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    clear_all();
    test_reset();
    test_priority_stall();
    test_mret_chain();
    test_s_exception();
    test_m_interrupt();
    test_mret_reset_abort();
    test_csr_conflicts();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
